// File: rtl/agc_xfer_sequencer_pkg.sv
// Shared definitions for the service-gate register-transfer sequencer.
// Contents:
//   REG_*          register codes used on the src/dst request fields
//   TPMAX_DEFAULT  timepulses per memory cycle
//   xfer_state_e   sequencer FSM states
//   strobe_lo()    active-low one-of-seven strobe decode, code 7 gives all-high
package agc_xfer_pkg;

    localparam logic [2:0] REG_A    = 3'd0;
    localparam logic [2:0] REG_L    = 3'd1;
    localparam logic [2:0] REG_Q    = 3'd2;
    localparam logic [2:0] REG_Z    = 3'd3;
    localparam logic [2:0] REG_B    = 3'd4;
    localparam logic [2:0] REG_G    = 3'd5;
    localparam logic [2:0] REG_UY   = 3'd6;
    localparam logic [2:0] REG_NONE = 3'd7;

    localparam int TPMAX_DEFAULT = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_RD,
        S_RW,
        S_ACK
    } xfer_state_e;

    // Bit 7 can never be driven low because code 7 means "no register".
    function automatic logic [7:0] strobe_lo(input logic [2:0] code);
        logic [7:0] v;
        v = 8'hFF;
        if (code != REG_NONE) begin
            v[code] = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/agc_xfer_sequencer_if.sv
// Requester/strobe bus of the transfer sequencer.
// Signals:
//   inh, req, src, dst        driven by the requester side (master)
//   rd_n, wr_n, ack, busy,
//   tp, mct                   driven by the sequencer (slave)
interface agc_xfer_sequencer_if #(
    parameter int NREQ = 4
);
    logic                inh;
    logic [NREQ-1:0]     req;
    logic [3*NREQ-1:0]   src;
    logic [3*NREQ-1:0]   dst;
    logic [7:0]          rd_n;
    logic [7:0]          wr_n;
    logic [NREQ-1:0]     ack;
    logic                busy;
    logic [3:0]          tp;
    logic                mct;

    modport master (
        output inh, req, src, dst,
        input  rd_n, wr_n, ack, busy, tp, mct
    );

    modport slave (
        input  inh, req, src, dst,
        output rd_n, wr_n, ack, busy, tp, mct
    );
endinterface

// File: rtl/agc_xfer_sequencer_arbiter.sv
// Combinational round-robin arbiter for the transfer sequencer.
// Ports:
//   ptr    in   index of the last winner; scanning starts at ptr+1
//   req    in   request vector
//   grant  out  one-hot winner (all zero when no request)
//   idx    out  binary index of the winner
module agc_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [IW-1:0]   ptr,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic found;
    int   cand;

    // Walk the requesters starting just after the previous winner so
    // the last winner has the lowest priority this time round.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/agc_xfer_sequencer.sv
// Register-transfer sequencer: free-running timepulse counter, round-robin
// grant of one src->dst transfer at a time, and active-low read/write
// control-pulse strobes with write overlapping read in the RW pulse.
// Ports:
//   CLOCK  in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   bus    slave side of agc_xfer_sequencer_if (inh/req/src/dst in,
//               rd_n/wr_n/ack/busy/tp/mct out, all outputs registered)
module agc_xfer_sequencer
    import agc_xfer_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TPMAX = TPMAX_DEFAULT
) (
    input  logic                 CLOCK,
    input  logic                 rst,
    agc_xfer_sequencer_if.slave  bus
);

    localparam int IW = $clog2(NREQ);

    xfer_state_e     state, state_next;
    logic [3:0]      tp, tp_next;
    logic [IW-1:0]   ptr, arb_idx;
    logic [NREQ-1:0] arb_grant, win;
    logic [2:0]      src_l, dst_l;
    logic [7:0]      rd_n, wr_n;
    logic [NREQ-1:0] ack;
    logic            busy, mct;
    logic            grant_ok;

    agc_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .ptr   (ptr),
        .req   (bus.req),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign tp_next = (tp == 4'(TPMAX)) ? 4'd1 : tp + 4'd1;

    // A grant needs three more pulses (GRANT, RD, RW), so the last legal
    // grant pulse is TPMAX-3 to keep RW inside the memory cycle.
    assign grant_ok = (state == S_IDLE) && (|bus.req) && !bus.inh &&
                      (tp <= 4'(TPMAX - 3));

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (grant_ok) state_next = S_GRANT;
            S_GRANT: state_next = S_RD;
            S_RD:    state_next = S_RW;
            S_RW:    state_next = S_ACK;
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes, ack and busy are decoded from the next state so they line
    // up with the state they belong to while still coming from flops.
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state <= S_IDLE;
            tp    <= 4'd1;
            mct   <= 1'b0;
            ptr   <= IW'(NREQ - 1);
            win   <= '0;
            src_l <= REG_NONE;
            dst_l <= REG_NONE;
            rd_n  <= 8'hFF;
            wr_n  <= 8'hFF;
            ack   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            tp    <= tp_next;
            mct   <= (tp_next == 4'(TPMAX));
            if (grant_ok) begin
                ptr   <= arb_idx;
                win   <= arb_grant;
                src_l <= bus.src[3*arb_idx +: 3];
                dst_l <= bus.dst[3*arb_idx +: 3];
            end
            rd_n <= (state_next == S_RD || state_next == S_RW) ? strobe_lo(src_l) : 8'hFF;
            wr_n <= (state_next == S_RW) ? strobe_lo(dst_l) : 8'hFF;
            ack  <= (state_next == S_ACK) ? win : '0;
            busy <= (state_next != S_IDLE);
        end
    end

    assign bus.rd_n = rd_n;
    assign bus.wr_n = wr_n;
    assign bus.ack  = ack;
    assign bus.busy = busy;
    assign bus.tp   = tp;
    assign bus.mct  = mct;

endmodule
